// File: rtl/id_pkg.sv
// id_pkg: shared decode definitions for the ID stage.
//   - opcode constants, ALUOp encodings
//   - id_ctrl_t: packed control bundle (7 control bits + ALUOp)
//   - decode_op(): opcode -> control; reads_rt(): opcode uses rt as a source
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;   // beq/bne; consumed in ID only, never registered
    logic [1:0] aluop;
  } id_ctrl_t;

  // Don't-care bits (sw RegDst/MemtoReg) and unknown opcodes decode to 0.
  function automatic id_ctrl_t decode_op(input logic [5:0] op);
    id_ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin c.regdst = 1'b1; c.regwrite = 1'b1; c.aluop = ALUOP_FUNCT; end
      OP_LW:    begin c.alusrc = 1'b1; c.memtoreg = 1'b1; c.regwrite = 1'b1; c.memread = 1'b1; end
      OP_SW:    begin c.alusrc = 1'b1; c.memwrite = 1'b1; end
      OP_ADDI:  begin c.alusrc = 1'b1; c.regwrite = 1'b1; end
      OP_BEQ, OP_BNE: begin c.branch = 1'b1; c.aluop = ALUOP_SUB; end
      default: ;
    endcase
    return c;
  endfunction

  // lw/addi use rt as a destination, so it must not trigger a load-use stall.
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/id_stage_param_if.sv
// id_stage_param_if: all non-clock/reset signals of the ID stage.
//   master: upstream/downstream environment (drives IF/ID, WB, EX/MEM side)
//   slave : the ID stage itself
// Optional: ID_PERF_CNT_EN adds perf_stall_cnt / perf_redirect_cnt.
interface id_stage_param_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  localparam int AW = $clog2(NREG);

  logic [31:0]     ifid_instr;
  logic [XLEN-1:0] ifid_pc_plus4;
  logic            ifid_valid;
  logic            wb_we;
  logic [AW-1:0]   wb_dst;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] exmem_result;
  logic            fwd_a, fwd_b;
  logic            ex_stall;

  logic            id_stall;
  logic            ifid_flush;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            idex_valid, idex_regwrite, idex_memtoreg, idex_memread;
  logic            idex_memwrite, idex_alusrc, idex_regdst;
  logic [1:0]      idex_aluop;
  logic [XLEN-1:0] idex_rdata1, idex_rdata2, idex_imm;
  logic [AW-1:0]   idex_rs, idex_rt, idex_rd;
`ifdef ID_PERF_CNT_EN
  logic [31:0]     perf_stall_cnt, perf_redirect_cnt;
`endif

  modport master (
    output ifid_instr, ifid_pc_plus4, ifid_valid, wb_we, wb_dst, wb_data,
           exmem_result, fwd_a, fwd_b, ex_stall,
    input  id_stall, ifid_flush, redirect_valid, redirect_target,
           idex_valid, idex_regwrite, idex_memtoreg, idex_memread,
           idex_memwrite, idex_alusrc, idex_regdst, idex_aluop,
           idex_rdata1, idex_rdata2, idex_imm, idex_rs, idex_rt, idex_rd
`ifdef ID_PERF_CNT_EN
    , input perf_stall_cnt, perf_redirect_cnt
`endif
  );

  modport slave (
    input  ifid_instr, ifid_pc_plus4, ifid_valid, wb_we, wb_dst, wb_data,
           exmem_result, fwd_a, fwd_b, ex_stall,
    output id_stall, ifid_flush, redirect_valid, redirect_target,
           idex_valid, idex_regwrite, idex_memtoreg, idex_memread,
           idex_memwrite, idex_alusrc, idex_regdst, idex_aluop,
           idex_rdata1, idex_rdata2, idex_imm, idex_rs, idex_rt, idex_rd
`ifdef ID_PERF_CNT_EN
    , output perf_stall_cnt, perf_redirect_cnt
`endif
  );
endinterface

// File: rtl/id_regfile.sv
// id_regfile: NREG x XLEN register file, 2 read / 1 write.
//   i_ra[p] -> o_rd[p] combinational, write-first bypass from the write port.
//   i_we/i_wa/i_wd write at the rising edge; register 0 is hardwired to 0.
//   reset_n synchronous active-low clears all registers.
module id_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [1:0][AW-1:0]        i_ra,
  output logic [1:0][XLEN-1:0]      o_rd,
  input  logic                      i_we,
  input  logic [AW-1:0]             i_wa,
  input  logic [XLEN-1:0]           i_wd
);
  logic [NREG-1:0][XLEN-1:0] r_mem;

  always_ff @(posedge clock) begin
    if (!reset_n)                 r_mem <= '0;
    else if (i_we && i_wa != '0)  r_mem[i_wa] <= i_wd;
  end

  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      o_rd[p] = r_mem[i_ra[p]];
      if (i_ra[p] == '0)                 o_rd[p] = '0;
      else if (i_we && i_wa == i_ra[p])  o_rd[p] = i_wd;
    end
  end
endmodule

// File: rtl/id_stage_param.sv
// id_stage_param: MIPS decode stage between IF/ID and ID/EX.
//   clock, reset_n (synchronous, active-low); everything else on bus (slave).
//   Register file read, control decode, branch/jump resolution in ID,
//   load-use hazard stalling for LOAD_USE_STALLS cycles, ID/EX register.
// Optional: define ID_PERF_CNT_EN for saturating stall/redirect counters.
module id_stage_param
  import id_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int NREG            = 32,
  parameter int LOAD_USE_STALLS = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  id_stage_param_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam logic [1:0] CNT_INIT = 2'(LOAD_USE_STALLS - 1);

  logic [5:0]            w_op;
  logic [4:0]            w_rs_f, w_rt_f, w_rd_f;
  logic [AW-1:0]         w_rs, w_rt, w_rd;
  id_ctrl_t              w_ctrl;
  logic [XLEN-1:0]       w_imm, w_opa, w_opb, w_br_tgt, w_j_tgt;
  logic [1:0][XLEN-1:0]  w_rdata;
  logic                  w_is_j, w_taken, w_hazard, w_stall_hz, w_redirect, w_load;

  logic [1:0]            r_cnt;
  logic                  r_valid, r_regwrite, r_memtoreg, r_memread, r_memwrite, r_alusrc, r_regdst;
  logic [1:0]            r_aluop;
  logic [XLEN-1:0]       r_rdata1, r_rdata2, r_imm;
  logic [AW-1:0]         r_rs, r_rt, r_rd;

  assign w_op   = bus.ifid_instr[31:26];
  assign w_rs_f = bus.ifid_instr[25:21];
  assign w_rt_f = bus.ifid_instr[20:16];
  assign w_rd_f = bus.ifid_instr[15:11];
  assign w_rs   = w_rs_f[AW-1:0];
  assign w_rt   = w_rt_f[AW-1:0];
  assign w_rd   = w_rd_f[AW-1:0];
  assign w_ctrl = decode_op(w_op);
  assign w_is_j = (w_op == OP_J);
  assign w_imm  = {{(XLEN-16){bus.ifid_instr[15]}}, bus.ifid_instr[15:0]};

  id_regfile #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rf (
    .clock   (clock),
    .reset_n (reset_n),
    .i_ra    ({w_rt, w_rs}),
    .o_rd    (w_rdata),
    .i_we    (bus.wb_we),
    .i_wa    (bus.wb_dst),
    .i_wd    (bus.wb_data)
  );

  // Branch resolution with EX/MEM forwarding of either compare operand.
  assign w_opa    = bus.fwd_a ? bus.exmem_result : w_rdata[0];
  assign w_opb    = bus.fwd_b ? bus.exmem_result : w_rdata[1];
  assign w_taken  = w_ctrl.branch & ((w_op == OP_BNE) ^ (w_opa == w_opb));
  assign w_br_tgt = bus.ifid_pc_plus4 + (w_imm << 2);
  assign w_j_tgt  = {bus.ifid_pc_plus4[XLEN-1:28], bus.ifid_instr[25:0], 2'b00};

  // rs is always compared; rt only when the ID instruction sources it.
  assign w_hazard   = r_valid & r_memread & (r_rt != '0) &
                      ((r_rt == w_rs) | (reads_rt(w_op) & (r_rt == w_rt)));
  assign w_stall_hz = w_hazard | (r_cnt != '0);
  assign w_redirect = bus.ifid_valid & ~(w_stall_hz | bus.ex_stall) & (w_is_j | w_taken);
  assign w_load     = bus.ifid_valid & ~w_stall_hz;

  assign bus.id_stall        = w_stall_hz | bus.ex_stall;
  assign bus.redirect_valid  = w_redirect;
  assign bus.ifid_flush      = w_redirect;
  assign bus.redirect_target = w_is_j ? w_j_tgt : w_br_tgt;

  // First hazard cycle loads LOAD_USE_STALLS-1 so the total stall is exact;
  // the bubble it inserts clears the hazard term for the following cycles.
  always_ff @(posedge clock) begin
    if (!reset_n) r_cnt <= '0;
    else if (!bus.ex_stall) begin
      if (r_cnt != '0)   r_cnt <= r_cnt - 2'd1;
      else if (w_hazard) r_cnt <= CNT_INIT;
    end
  end

  // ID/EX: hold on ex_stall, otherwise load decode or a zeroed bubble.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_valid <= 1'b0; r_regwrite <= 1'b0; r_memtoreg <= 1'b0; r_memread <= 1'b0;
      r_memwrite <= 1'b0; r_alusrc <= 1'b0; r_regdst <= 1'b0; r_aluop <= '0;
      r_rdata1 <= '0; r_rdata2 <= '0; r_imm <= '0; r_rs <= '0; r_rt <= '0; r_rd <= '0;
    end else if (!bus.ex_stall) begin
      r_valid    <= w_load;
      r_regwrite <= w_load & w_ctrl.regwrite;
      r_memtoreg <= w_load & w_ctrl.memtoreg;
      r_memread  <= w_load & w_ctrl.memread;
      r_memwrite <= w_load & w_ctrl.memwrite;
      r_alusrc   <= w_load & w_ctrl.alusrc;
      r_regdst   <= w_load & w_ctrl.regdst;
      r_aluop    <= w_load ? w_ctrl.aluop : '0;
      r_rdata1   <= w_load ? w_rdata[0]   : '0;
      r_rdata2   <= w_load ? w_rdata[1]   : '0;
      r_imm      <= w_load ? w_imm        : '0;
      r_rs       <= w_load ? w_rs         : '0;
      r_rt       <= w_load ? w_rt         : '0;
      r_rd       <= w_load ? w_rd         : '0;
    end
  end

  assign bus.idex_valid    = r_valid;
  assign bus.idex_regwrite = r_regwrite;
  assign bus.idex_memtoreg = r_memtoreg;
  assign bus.idex_memread  = r_memread;
  assign bus.idex_memwrite = r_memwrite;
  assign bus.idex_alusrc   = r_alusrc;
  assign bus.idex_regdst   = r_regdst;
  assign bus.idex_aluop    = r_aluop;
  assign bus.idex_rdata1   = r_rdata1;
  assign bus.idex_rdata2   = r_rdata2;
  assign bus.idex_imm      = r_imm;
  assign bus.idex_rs       = r_rs;
  assign bus.idex_rt       = r_rt;
  assign bus.idex_rd       = r_rd;

`ifdef ID_PERF_CNT_EN
  // Stall count covers every cycle the hazard logic holds ID, including
  // cycles where ex_stall is also asserted.
  logic [31:0] r_perf_stall, r_perf_redir;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_perf_stall <= '0;
      r_perf_redir <= '0;
    end else begin
      if (w_stall_hz && r_perf_stall != '1) r_perf_stall <= r_perf_stall + 32'd1;
      if (w_redirect && r_perf_redir != '1) r_perf_redir <= r_perf_redir + 32'd1;
    end
  end
  assign bus.perf_stall_cnt    = r_perf_stall;
  assign bus.perf_redirect_cnt = r_perf_redir;
`endif
endmodule

// File: doc/id_stage_param.md
Name: id_stage_param

Overview:
- Parametrised next-generation decode (ID) stage for the 5-stage MIPS pipeline. Sits between the IF/ID and ID/EX pipeline registers.
- Holds the register file with write-first bypass, decodes control, and resolves branches and jumps in ID.
- Detects load-use hazards internally and inserts a configurable number of bubbles, counted by a stall counter.
- Owns the ID/EX pipeline register, with hold on downstream stall and bubble on hazard.

Parameters:
- XLEN, 32, datapath width; must be >= 32.
- NREG, 32, register count; power of two, 2..32; AW = clog2(NREG).
- LOAD_USE_STALLS, 1, bubbles inserted per load-use hazard; range 1..3.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- ifid_instr  in  32  instruction in ID.
- ifid_pc_plus4  in  XLEN  PC+4 of the instruction in ID.
- ifid_valid  in  1  the ID instruction is real.
- wb_we  in  1  writeback enable.
- wb_dst  in  AW  writeback register.
- wb_data  in  XLEN  writeback value.
- exmem_result  in  XLEN  EX/MEM ALU result, used for branch forwarding.
- fwd_a, fwd_b  in  1  select exmem_result as branch compare operand A or B.
- ex_stall  in  1  downstream stall; hold ID/EX.
- id_stall  out  1  hold PC and IF/ID.
- ifid_flush  out  1  squash IF/ID.
- redirect_valid  out  1  taken branch or jump.
- redirect_target  out  XLEN  next PC.
- idex_valid, idex_regwrite, idex_memtoreg, idex_memread, idex_memwrite, idex_alusrc, idex_regdst  out  1 each  registered control.
- idex_aluop  out  2  registered ALUOp.
- idex_rdata1, idex_rdata2, idex_imm  out  XLEN  registered operands and sign-extended immediate.
- idex_rs, idex_rt, idex_rd  out  AW  registered register specifiers.

Behaviour:
- Reset: while reset_n=0 at a clock edge, all ID/EX outputs clear to 0, all registers clear to 0, and the stall counter clears to 0.
- Register file:
  - Register 0 always reads 0.
  - Write at the clock edge when wb_we=1 and wb_dst!=0.
  - Read is write-first: if wb_we=1 and wb_dst==rs (or rt), with the index !=0, the read returns wb_data in the same cycle.
  - Register index = instr field[AW-1:0].
- Decode (opcode; signals RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp):
  - 0x00 R-type: 1,0,0,1,0,0,10.
  - 0x23 lw: 0,1,1,1,1,0,00.
  - 0x2B sw: x,1,x,0,0,1,00.
  - 0x08 addi: 0,1,0,1,0,0,00.
  - 0x04 beq / 0x05 bne: ALUOp=01, no write.
  - 0x02 j: all 0.
  - Unknown opcode: all 0; the instruction still enters ID/EX with idex_valid=1.
- Branch target = ifid_pc_plus4 + (sext(imm16) << 2), mod 2^XLEN.
- Jump target = {ifid_pc_plus4[XLEN-1:28], instr[25:0], 2'b00}.
- Branch compare:
  - Operand A = fwd_a ? exmem_result : rs read; operand B likewise with fwd_b.
  - beq is taken when A==B; bne is taken when A!=B.
- redirect_valid = ifid_valid & !id_stall & (j | taken branch). Combinational, same cycle.
- ifid_flush = redirect_valid.
- Load-use hazard: idex_valid & idex_memread & idex_rt!=0 & (idex_rt==rs, or idex_rt==rt for an instruction that reads rt).
- Stall counter:
  - On a hazard with cnt==0: load cnt = LOAD_USE_STALLS-1 and stall.
  - While cnt>0: stall and decrement.
  - Total stall = exactly LOAD_USE_STALLS cycles.
- id_stall = hazard_or_cnt | ex_stall.
- ID/EX update priority at each edge:
  - reset.
  - ex_stall=1: hold all ID/EX values; the counter also holds.
  - hazard stall: load a bubble (all control 0, idex_valid=0; data fields don't-care, driven 0).
  - ifid_valid=0: bubble.
  - otherwise: load the decoded instruction.
- A branch or jump itself enters ID/EX (no write side effects).
- Reset asserted mid-stall clears the counter; the first cycle after reset never stalls.

Optional Feature:
- Macro ID_PERF_CNT_EN.
- When defined, adds outputs perf_stall_cnt[31:0] and perf_redirect_cnt[31:0]:
  - perf_stall_cnt counts cycles with a hazard stall.
  - perf_redirect_cnt counts cycles with redirect_valid=1.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package id_pkg holds:
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_BNE, OP_J);
  - ALUOp encodings;
  - a packed id_ctrl_t struct with the 7 control bits plus ALUOp.
- One sub-module, id_regfile, parametrised by XLEN/NREG: 2 read ports, 1 write port, write-first bypass, synchronous reset clear.

Test Plan:
- Reset, then drive wb_we=1, wb_dst=8, wb_data=0x12345678 with ifid_instr=0x20080020 (addi $8,$0,0x20) → idex_rdata1=0, idex_imm=0x20, idex_regwrite=1, idex_alusrc=1. A following read of $8 returns 0x12345678 via bypass in the same cycle as the write.
- Write to $0 with wb_data=0xFFFFFFFF → $0 still reads 0.
- beq $17,$18,+18 at pc_plus4=12 with fwd_a=fwd_b=1 → redirect_valid=1, ifid_flush=1, redirect_target=0x54. With fwd_b=0 and $18≠exmem_result → no redirect.
- j 0x17 at pc_plus4=12 → redirect_target=0x5C, ifid_flush=1.
- lw $9 in EX, then add $10,$9,$9 in ID, with LOAD_USE_STALLS=2 → id_stall high for exactly 2 cycles, 2 bubbles (idex_valid=0), then the add loads. Assert ex_stall mid-sequence → all ID/EX values and the counter hold.
- reset_n low during stall cnt=1 → counter clears; no stall on the first post-reset cycle. With ID_PERF_CNT_EN, perf_stall_cnt==0 after reset.
